// File: rtl/user_proj_wb_pkg.sv
// Shared constants for the Wishbone counter: register map, bit indices, reset values.
// Also holds the byte-lane merge helper used by the register file.
package user_proj_wb_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_COUNT    = 8'h04;
    localparam logic [7:0] OFF_LIMIT    = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;
    localparam logic [7:0] OFF_PRESCALE = 8'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_DOWN   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_OE     = 3;

    localparam int STATUS_WRAP = 0;

    localparam logic [31:0] LIMIT_RST = 32'hFFFF_FFFF;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old,
        input logic [31:0] wdat,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/user_proj_cnt_core.sv
// Counter core: run gating, optional prescaler (USER_PROJ_PRESCALE_EN), up/down wrap.
// A bus write to COUNT overrides any tick in the same cycle and suppresses wrap.
module user_proj_cnt_core #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               down,
    input  logic [COUNT_W-1:0] limit,
    input  logic               wr_en,
    input  logic [COUNT_W-1:0] wr_data,
`ifdef USER_PROJ_PRESCALE_EN
    input  logic [15:0]        prescale,
`endif
    output logic [COUNT_W-1:0] count,
    output logic               wrap
);

    logic               tick;
    logic               roll;
    logic [COUNT_W-1:0] nxt;

`ifdef USER_PROJ_PRESCALE_EN
    logic [15:0] pdiv;

    // >= so that lowering PRESCALE below the running divider still ticks at once
    assign tick = run & (pdiv >= prescale);

    always_ff @(posedge clk) begin
        if (rst) begin
            pdiv <= '0;
        end else if (run) begin
            pdiv <= tick ? 16'd0 : pdiv + 16'd1;
        end
    end
`else
    assign tick = run;
`endif

    always_comb begin
        nxt  = count;
        roll = 1'b0;
        if (down) begin
            if (count == '0) begin
                nxt  = limit;
                roll = 1'b1;
            end else begin
                nxt = count - COUNT_W'(1);
            end
        end else if (count == limit) begin
            nxt  = '0;
            roll = 1'b1;
        end else begin
            // LIMIT below COUNT: run to the top and flag the natural rollover
            nxt  = count + COUNT_W'(1);
            roll = (count == '1);
        end
    end

    assign wrap = tick & ~wr_en & roll;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_en) begin
            count <= wr_data;
        end else if (tick) begin
            count <= nxt;
        end
    end

endmodule

// File: rtl/user_proj_wb_counter.sv
// Wishbone-controlled counter driving user GPIO pads, LA readback and irq[0].
// Optional prescaler register at 0x10 when USER_PROJ_PRESCALE_EN is defined.
import user_proj_wb_pkg::*;

module user_proj_wb_counter #(
    parameter int          COUNT_W  = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          IO_PADS  = 38,
    parameter int          OUT_LSB  = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [31:0]        wbs_adr_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic [63:0]        la_data_in,
    input  logic [63:0]        la_oenb,
    output logic [63:0]        la_data_out,
    input  logic [IO_PADS-1:0] io_in,
    output logic [IO_PADS-1:0] io_out,
    output logic [IO_PADS-1:0] io_oeb,
    output logic [2:0]         irq
);

    localparam int OUT_W = IO_PADS - OUT_LSB;

    logic [3:0]         ctrl;
    logic [COUNT_W-1:0] limit;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] cnt_wr_data;
    logic               wrap_sts;
    logic               wrap;
    logic               irq0;
    logic               ack;
    logic [31:0]        dat_q;
    logic [31:0]        rdata;
    logic [31:0]        cnt_merged;
    logic [31:0]        lim_merged;
    logic [63:0]        cnt_pad;
    logic [63:0]        io_pad64;
    logic [7:0]         off;
    logic               hit;
    logic               req;
    logic               wr;
    logic               run;
    logic               unused;
`ifdef USER_PROJ_PRESCALE_EN
    logic [15:0]        prescale;
`endif

    assign off = wbs_adr_i[7:0];
    assign hit = wbs_adr_i[31:8] == BASE_ADR[31:8];
    // gating with ack keeps each ack exactly one cycle wide
    assign req = wbs_stb_i & wbs_cyc_i & hit & ~ack;
    assign wr  = req & wbs_we_i;
    assign run = ctrl[CTRL_EN] | (~la_oenb[0] & la_data_in[0]);

    assign cnt_merged  = merge_bytes(32'(count), wbs_dat_i, wbs_sel_i);
    assign lim_merged  = merge_bytes(32'(limit), wbs_dat_i, wbs_sel_i);
    assign cnt_wr_data = cnt_merged[COUNT_W-1:0];

    user_proj_cnt_core #(
        .COUNT_W (COUNT_W)
    ) u_core (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .run      (run),
        .down     (ctrl[CTRL_DOWN]),
        .limit    (limit),
        .wr_en    (wr && off == OFF_COUNT),
        .wr_data  (cnt_wr_data),
`ifdef USER_PROJ_PRESCALE_EN
        .prescale (prescale),
`endif
        .count    (count),
        .wrap     (wrap)
    );

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:     rdata = 32'(ctrl);
            OFF_COUNT:    rdata = 32'(count);
            OFF_LIMIT:    rdata = 32'(limit);
            OFF_STATUS:   rdata = 32'(wrap_sts);
`ifdef USER_PROJ_PRESCALE_EN
            OFF_PRESCALE: rdata = 32'(prescale);
`endif
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack      <= 1'b0;
            dat_q    <= '0;
            ctrl     <= '0;
            limit    <= LIMIT_RST[COUNT_W-1:0];
            wrap_sts <= 1'b0;
            irq0     <= 1'b0;
        end else begin
            ack   <= req;
            dat_q <= (req & ~wbs_we_i) ? rdata : '0;
            irq0  <= wrap & ctrl[CTRL_IRQ_EN];
            // a wrap in the same cycle as the clear keeps the flag set
            wrap_sts <= (wrap_sts & ~(wr && off == OFF_STATUS &&
                         wbs_sel_i[0] && wbs_dat_i[STATUS_WRAP])) | wrap;
            if (wr && off == OFF_CTRL && wbs_sel_i[0]) begin
                ctrl <= wbs_dat_i[3:0];
            end
            if (wr && off == OFF_LIMIT) begin
                limit <= lim_merged[COUNT_W-1:0];
            end
        end
    end

`ifdef USER_PROJ_PRESCALE_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prescale <= '0;
        end else if (wr && off == OFF_PRESCALE) begin
            if (wbs_sel_i[0]) prescale[7:0]  <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) prescale[15:8] <= wbs_dat_i[15:8];
        end
    end
`endif

    assign cnt_pad  = 64'(count);
    assign io_pad64 = 64'(io_in);

    assign wbs_ack_o   = ack;
    assign wbs_dat_o   = dat_q;
    assign io_out      = {cnt_pad[OUT_W-1:0], {OUT_LSB{1'b0}}};
    assign io_oeb      = {{OUT_W{~ctrl[CTRL_OE]}}, {OUT_LSB{1'b1}}};
    assign la_data_out = {io_pad64[31:0], cnt_pad[31:0]};
    assign irq         = {2'b00, irq0};

    assign unused = ^{la_data_in, la_oenb, cnt_pad, io_pad64,
                      cnt_merged, lim_merged};

endmodule

// File: tb/tb_user_proj_wb_counter.sv
// Randomized scoreboard bench for user_proj_wb_counter against a behavioural model.
// Build with USER_PROJ_PRESCALE_EN defined to also cover the prescaler register.
module tb_user_proj_wb_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [63:0] la_data_in = '0;
    logic [63:0] la_oenb = '1;
    logic [63:0] la_data_out;
    logic [37:0] io_in = '0;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    logic [2:0]  irq;

    always #5 clk = ~clk;

    user_proj_wb_counter dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // {is_write, expected read data}
    logic [32:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] old,
                                           input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Reference model state
    logic [3:0]  m_ctrl  = '0;
    logic [31:0] m_count = '0;
    logic [31:0] m_limit = 32'hFFFF_FFFF;
    logic        m_wrap  = 1'b0;
    logic        m_irq   = 1'b0;
    logic        m_ack   = 1'b0;
    logic [15:0] m_pre   = '0;
    int          m_pdiv  = 0;

    function automatic logic [31:0] m_read(input logic [7:0] o);
        case (o)
            8'h00: return {28'b0, m_ctrl};
            8'h04: return m_count;
            8'h08: return m_limit;
            8'h0C: return {31'b0, m_wrap};
`ifdef USER_PROJ_PRESCALE_EN
            8'h10: return {16'b0, m_pre};
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic       req;
        logic       run;
        logic       tick;
        logic       wrapped;
        logic       clr;
        logic [7:0] o;
        logic [31:0] tmp;
        if (rst) begin
            m_ctrl = '0; m_count = '0; m_limit = 32'hFFFF_FFFF;
            m_wrap = 0; m_irq = 0; m_ack = 0; m_pre = '0; m_pdiv = 0;
        end else begin
            o   = wbs_adr_i[7:0];
            req = wbs_stb_i && wbs_cyc_i &&
                  (wbs_adr_i[31:8] == 24'h30_0000) && !m_ack;
            if (req) exp_q.push_back({wbs_we_i, m_read(o)});
            run = m_ctrl[0] || (!la_oenb[0] && la_data_in[0]);
`ifdef USER_PROJ_PRESCALE_EN
            tick = run && (m_pdiv >= int'(m_pre));
            if (run) m_pdiv = tick ? 0 : m_pdiv + 1;
`else
            tick = run;
`endif
            wrapped = 0;
            if (req && wbs_we_i && o == 8'h04) begin
                m_count = bmerge(m_count, wbs_dat_i, wbs_sel_i);
            end else if (tick) begin
                if (m_ctrl[1]) begin
                    wrapped = (m_count == 0);
                    m_count = wrapped ? m_limit : m_count - 1;
                end else begin
                    m_count = (m_count == m_limit) ? 32'h0 : m_count + 1;
                    wrapped = (m_count == 0);
                end
            end
            clr = req && wbs_we_i && o == 8'h0C && wbs_sel_i[0] && wbs_dat_i[0];
            m_wrap = (m_wrap && !clr) || wrapped;
            m_irq  = wrapped && m_ctrl[2];
            if (req && wbs_we_i) begin
                if (o == 8'h00 && wbs_sel_i[0]) m_ctrl = wbs_dat_i[3:0];
                if (o == 8'h08) m_limit = bmerge(m_limit, wbs_dat_i, wbs_sel_i);
`ifdef USER_PROJ_PRESCALE_EN
                if (o == 8'h10) begin
                    tmp = bmerge({16'b0, m_pre}, wbs_dat_i, wbs_sel_i);
                    m_pre = tmp[15:0];
                end
`endif
            end
            m_ack = req;
        end
    end

    // Monitor: pops an expectation whenever the DUT acks
    always @(negedge clk) begin
        logic [32:0] e;
        chk("ack", 64'(wbs_ack_o), 64'(m_ack));
        if (wbs_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack_unexpected: got ack, required no ack");
            end else begin
                e = exp_q.pop_front();
                if (!e[32]) chk("rdata", 64'(wbs_dat_o), 64'(e[31:0]));
            end
        end else begin
            chk("dat_idle", 64'(wbs_dat_o), 64'h0);
        end
        chk("irq", 64'(irq), {61'b0, 2'b00, m_irq});
        chk("io_out", 64'(io_out), 64'({m_count[29:0], 8'h00}));
        chk("io_oeb", 64'(io_oeb), 64'({{30{~m_ctrl[3]}}, 8'hFF}));
        chk("la_out", la_data_out, {io_in[31:0], m_count});
    end

    task automatic wb(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
        int lat;
        logic hit;
        hit = (a[31:8] == 24'h30_0000);
        @(posedge clk);
        #1;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = w;
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (wbs_ack_o) begin
                lat = i;
                break;
            end
        end
        chk(hit ? "ack_latency" : "miss_noack", 64'(lat), hit ? 64'd1 : 64'd0);
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        wb(1'b1, 32'h3000_0000 | 32'(o), d, 4'hF);
    endtask

    task automatic rd(input logic [7:0] o);
        wb(1'b0, 32'h3000_0000 | 32'(o), 32'h0, 4'hF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c0;
        logic        got;
        logic [7:0]  offs [8];
        logic [7:0]  o;
        logic [31:0] d;
        int          r;

        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h02};

        repeat (4) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        chk("rst_la", la_data_out, 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        rd(8'h00); rd(8'h04); rd(8'h08);

        // Up count with LIMIT=3, irq at the wrap
        wr(8'h08, 32'd3);
        wr(8'h00, 32'h5);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (irq[0]) begin
                got = 1;
                break;
            end
        end
        chk("irq_seen", 64'(got), 64'd1);
        chk("wrap_to_zero", 64'(la_data_out[31:0]), 64'h0);
        @(negedge clk);
        chk("irq_one_cycle", 64'(irq[0]), 64'h0);
        wr(8'h00, 32'h4);
        rd(8'h0C);
        wr(8'h0C, 32'h1);
        rd(8'h0C);

        // Down count from 0 loads LIMIT
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h0);
        wr(8'h08, 32'd5);
        wr(8'h00, 32'h3);
        repeat (2) @(negedge clk);
        chk("down_wrap", 64'(la_data_out[31:0]), 64'd5);
        wr(8'h00, 32'h0);
        rd(8'h0C);

        // Byte-lane write to COUNT while ticking
        wr(8'h08, 32'hFFFF_FFFF);
        wr(8'h04, 32'hAABB_CC00);
        wr(8'h00, 32'h1);
        wb(1'b1, 32'h3000_0004, 32'h0000_0010, 4'b0001);
        @(negedge clk);
        chk("write_wins", 64'(la_data_out[31:0]), 64'hAABB_CC10);
        @(negedge clk);
        chk("after_write", 64'(la_data_out[31:0]), 64'hAABB_CC11);

        // Pad drive
        wr(8'h00, 32'h0);
        wr(8'h04, 32'hA5);
        wr(8'h00, 32'h8);
        @(negedge clk);
        chk("io_out_a5", 64'(io_out[15:8]), 64'hA5);
        chk("io_oeb_oe", 64'(io_oeb), 64'h00_0000_00FF);

        // LA run override with EN=0
        wr(8'h00, 32'h0);
        la_oenb = ~64'h1;
        la_data_in = 64'h1;
        @(negedge clk);
        c0 = la_data_out[31:0];
        repeat (5) @(negedge clk);
        chk("la_override", 64'(la_data_out[31:0] - c0), 64'd5);
        @(posedge clk);
        #1;
        la_oenb = '1;
        la_data_in = '0;

`ifdef USER_PROJ_PRESCALE_EN
        wr(8'h10, 32'd2);
        wr(8'h00, 32'h1);
        @(negedge clk);
        c0 = la_data_out[31:0];
        repeat (9) @(negedge clk);
        chk("prescale_rate", 64'(la_data_out[31:0] - c0), 64'd3);
        wr(8'h00, 32'h0);
        wr(8'h10, 32'd0);
`endif

        // Reset together with a request: no ack
        @(posedge clk);
        #1;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0;
        wbs_adr_i = 32'h3000_0004;
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst_noack", 64'(wbs_ack_o), 64'h0);
        wbs_stb_i = 0; wbs_cyc_i = 0;
        rst = 0;

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            io_in = 38'({$urandom(), $urandom()});
            la_oenb[0] = ($urandom_range(0, 3) != 0);
            la_data_in[0] = 1'($urandom());
            o = offs[$urandom_range(0, 7)];
            r = $urandom_range(0, 9);
            case (o)
                8'h00: d = 32'($urandom_range(0, 15));
                8'h08: d = (r < 7) ? 32'($urandom_range(0, 12)) : $urandom();
                8'h04: d = (r < 4) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                   : 32'($urandom_range(0, 15));
                8'h10: d = 32'($urandom_range(0, 3));
                default: d = $urandom();
            endcase
            if (r == 9) begin
                wb(1'($urandom()), 32'h3000_0100 | 32'(o), d, 4'hF);
            end else if (r < 5) begin
                wb(1'b1, 32'h3000_0000 | 32'(o), d,
                   (r == 0) ? 4'($urandom()) : 4'hF);
            end else begin
                rd(o);
            end
        end

        wr(8'h00, 32'h0);
        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
